// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - 8N1 serial transmitter with configurable bit time and stop bits
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // Timer counts down from this value, so a bit lasts exactly CLKS_PER_BIT cycles.
    localparam logic [15:0] BIT_RELOAD = 16'(CLKS_PER_BIT - 1);
    // Index of the final stop bit; a 1-bit counter covers both 1 and 2 stop bits.
    localparam logic        STOP_LAST  = 1'(STOP_BITS - 1);

    state_t      cur_state;
    logic [15:0] timer;
    logic [2:0]  bit_cnt;
    logic        stop_cnt;
    logic [7:0]  shift;
    logic        tx_q;
    logic        busy_q;
    logic        done_q;
    logic        timer_zero;

    assign timer_zero = (timer == 16'd0);

    assign tx    = tx_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign state = cur_state;

    // Frame sequencer: every output comes straight from a flop so the line never glitches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_state <= S_IDLE;
            timer     <= 16'd0;
            bit_cnt   <= 3'd0;
            stop_cnt  <= 1'b0;
            shift     <= 8'd0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (cur_state)
                S_IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    // Also taken in the done cycle, giving back-to-back frames with a one-cycle longer stop.
                    if (tx_start) begin
                        shift     <= tx_data;
                        timer     <= BIT_RELOAD;
                        tx_q      <= 1'b0;
                        busy_q    <= 1'b1;
                        cur_state <= S_START;
                    end
                end

                S_START: begin
                    if (timer_zero) begin
                        tx_q      <= shift[0];
                        timer     <= BIT_RELOAD;
                        bit_cnt   <= 3'd0;
                        cur_state <= S_DATA;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end

                S_DATA: begin
                    if (timer_zero) begin
                        timer <= BIT_RELOAD;
                        if (bit_cnt == 3'd7) begin
                            tx_q      <= 1'b1;
                            stop_cnt  <= 1'b0;
                            cur_state <= S_STOP;
                        end else begin
                            // Next bit is shift[1] now, which becomes shift[0] after this shift.
                            shift   <= {1'b0, shift[7:1]};
                            tx_q    <= shift[1];
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end

                S_STOP: begin
                    if (timer_zero) begin
                        if (stop_cnt == STOP_LAST) begin
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            bit_cnt   <= 3'd0;
                            stop_cnt  <= 1'b0;
                            timer     <= 16'd0;
                            cur_state <= S_IDLE;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                            timer    <= BIT_RELOAD;
                        end
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end

                default: begin
                    tx_q      <= 1'b1;
                    busy_q    <= 1'b0;
                    cur_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - scoreboard bench for uart_transmitter (1 and 2 stop bits)
module tb_uart_transmitter;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_start0, tx_start1;
    logic [7:0] tx_data0, tx_data1;
    logic       tx0, busy0, done0, tx1, busy1, done1;
    logic [1:0] state0, state1;

    int checks = 0;
    int failures = 0;
    int idle_errs[2];
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    uart_transmitter #(.CLKS_PER_BIT(8), .STOP_BITS(1)) dut0 (
        .clk(clk), .reset(reset), .tx_start(tx_start0), .tx_data(tx_data0),
        .tx(tx0), .busy(busy0), .done(done0), .state(state0)
    );

    uart_transmitter #(.CLKS_PER_BIT(8), .STOP_BITS(2)) dut1 (
        .clk(clk), .reset(reset), .tx_start(tx_start1), .tx_data(tx_data1),
        .tx(tx1), .busy(busy1), .done(done1), .state(state1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    // {tx, busy, done, state}
    function automatic logic [4:0] obs(input int i);
        return (i == 0) ? {tx0, busy0, done0, state0} : {tx1, busy1, done1, state1};
    endfunction

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [7:0] qpop(input int i);
        return (i == 0) ? q0.pop_front() : q1.pop_front();
    endfunction

    // Caller is positioned just after a negedge; the request is accepted on the next posedge.
    task automatic send(input int idx, input logic [7:0] b);
        if (idx == 0) begin
            tx_data0 = b; tx_start0 = 1'b1; q0.push_back(b);
        end else begin
            tx_data1 = b; tx_start1 = 1'b1; q1.push_back(b);
        end
        @(negedge clk);
        if (idx == 0) tx_start0 = 1'b0;
        else          tx_start1 = 1'b0;
    endtask

    task automatic wait_done(input int idx);
        logic [4:0] o;
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            o = obs(idx);
            if (o[2]) seen = 1'b1;
        end
        if (!seen) chk($sformatf("done_timeout%0d", idx), 0, 1);
    endtask

    // Decodes each frame cycle by cycle against the expected byte from the scoreboard queue.
    task automatic monitor(input int idx, input int sb);
        logic [4:0] o;
        logic [7:0] e;
        logic       eb;
        logic       aborted;
        int         n, errs, first, slot;
        n = (9 + sb) * 8;
        forever begin
            @(negedge clk);
            o = obs(idx);
            if (!reset) continue;
            if (o[4]) begin
                if (o[3] || o[2]) idle_errs[idx]++;
                continue;
            end
            if (qsize(idx) == 0) begin
                chk($sformatf("unexpected_frame%0d", idx), 1, 0);
                e = 8'h00;
            end else begin
                e = qpop(idx);
            end
            errs = 0; first = -1; aborted = 1'b0;
            for (int c = 0; c < n; c++) begin
                if (c > 0) @(negedge clk);
                if (!reset) begin
                    aborted = 1'b1;
                    break;
                end
                o = obs(idx);
                slot = c / 8;
                eb = (slot == 0) ? 1'b0 : (slot <= 8) ? e[slot-1] : 1'b1;
                if (o[4:2] !== {eb, 1'b1, 1'b0}) begin
                    errs++;
                    if (first < 0) first = c;
                end
            end
            if (aborted) continue;
            chk($sformatf("frame%0d_byte%02h_badcycles_first%0d", idx, e, first), errs, 0);
            @(negedge clk);
            if (!reset) continue;
            o = obs(idx);
            chk($sformatf("done_cycle%0d_byte%02h", idx, e), o[4:2], 3'b101);
        end
    endtask

    initial begin
        logic [4:0] o;
        idle_errs[0] = 0; idle_errs[1] = 0;
        tx_start0 = 1'b0; tx_start1 = 1'b0;
        tx_data0 = 8'h00; tx_data1 = 8'h00;
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        chk("reset_vals0", obs(0), 5'b10000);
        chk("reset_vals1", obs(1), 5'b10000);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        fork
            monitor(0, 1);
            monitor(1, 2);
        join_none
        repeat (20) @(negedge clk);
        chk("idle_after_reset0", obs(0), 5'b10000);
        chk("idle_after_reset1", obs(1), 5'b10000);

        send(0, 8'hA5);
        wait_done(0);
        @(negedge clk);

        send(0, 8'hFF);
        repeat (20) @(negedge clk);
        tx_data0 = 8'h3C; tx_start0 = 1'b1;
        @(negedge clk);
        tx_start0 = 1'b0;
        repeat (10) @(negedge clk);
        tx_data0 = 8'h11;
        wait_done(0);
        repeat (100) @(negedge clk);

        send(0, 8'hC3);
        wait_done(0);
        send(0, 8'h00);
        o = obs(0);
        chk("b2b_start_no_gap", o[4:3], 2'b01);
        wait_done(0);
        @(negedge clk);

        send(0, 8'hF0);
        repeat (34) @(negedge clk);
        chk("mid_frame_data_bit3", obs(0), 5'b01010);
        #2 reset = 1'b0;
        #1;
        chk("reset_mid_frame", obs(0), 5'b10000);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        repeat (4) @(negedge clk);
        send(0, 8'h5A);
        wait_done(0);
        @(negedge clk);

        send(1, 8'h00); wait_done(1);
        send(1, 8'hFF); wait_done(1);
        send(1, 8'h81); wait_done(1);
        for (int k = 0; k < 256; k++) begin
            send(1, 8'($urandom_range(0, 255)));
            wait_done(1);
        end

        repeat (50) @(negedge clk);
        chk("queue0_drained", q0.size(), 0);
        chk("queue1_drained", q1.size(), 0);
        chk("idle_errors0", idle_errs[0], 0);
        chk("idle_errors1", idle_errs[1], 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
